hazard_ctrl_param: RTL and testbench
====================================

# hazard_ctrl_param

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID stage and driving PC write-enable, IF/ID write-enable, ID/EX bubble insertion and the next-PC mux select. It generalises our single-cycle load-use/jump/branch controller:
- configurable load-use stall length, taken-branch flush depth and number of in-flight writer stages checked for `jr`;
- register-0 hazard suppression;
- a stall handshake for the multi-cycle mul/div unit.

## Interface
Parameters:
- `RW`, 5: register address width.
- `NWB`, 2: number of in-flight writer stages checked for `jr` source hazards.
- `LD_STALL`, 1: load-use stall cycles, legal 1..3.
- `BR_FLUSH`, 1: bubble cycles after a taken branch redirect, legal 1..3.

Ports:
- `Clk` in 1: clock, rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `Jump`, `Jr`, `Branch` in 1: ID-stage decode flags.
- `BranchTaken` in 1: branch outcome, valid in the cycle after `Branch`.
- `memReadEX` in 1: EX-stage instruction is a load.
- `UseShamt`, `UseImmed` in 1: ID instruction does not read `currRt`.
- `mdUse` in 1: ID instruction reads HI/LO or issues mul/div.
- `mdBusy` in 1: mul/div unit busy.
- `currRs`, `currRt` in RW: ID source registers.
- `prevRt` in RW: EX load destination.
- `wbDst` in NWB*RW: destination of writer stage k, at bits [k*RW +: RW]; k=0 is the youngest.
- `wbWr` in NWB: writer stage k writes the register file.
- `PC_Write`, `IF_Write`, `bubble` out 1: PC enable, IF/ID enable, ID/EX bubble.
- `addrSel` out 2: next PC select. 00 = PC+4, 01 = jump/jr target, 10 = branch target.
- `hzState` out 3: current state, for debug and verification.

## Operation
Terms:
- NORM = {PC_Write, IF_Write, bubble, addrSel} = {1,1,0,00}.
- STALL = {0,0,1,00}.
- LdHaz = memReadEX & prevRt≠0 & (currRs==prevRt | (currRt==prevRt & !UseImmed & !UseShamt)).
- JrHaz = OR over k of (wbWr[k] & wbDst[k]==currRs) & currRs≠0.
- MdHaz = mdUse & mdBusy.

States and encodings: IDLE 0, LDSTALL 1, JUMP 2, JRWAIT 3, BRWAIT 4, BRFLUSH 5, MDWAIT 6. Encoding 7 behaves as IDLE and goes to IDLE.

IDLE decision, first match wins:
1. Jump: {1,0,0,01} -> JUMP.
2. Jr & JrHaz: {0,0,1,01} -> JRWAIT.
3. Jr: {1,0,1,01} -> JUMP.
4. LdHaz: STALL, cnt<=LD_STALL-1 -> LDSTALL.
5. MdHaz: STALL -> MDWAIT.
6. Branch: NORM -> BRWAIT.
7. Otherwise: NORM, stay in IDLE.

Other states:
- LDSTALL: if cnt≠0, STALL and cnt<=cnt-1; if cnt==0, NORM -> IDLE.
- JUMP: NORM -> IDLE.
- JRWAIT: if JrHaz, {0,0,1,01}, stay; else {1,0,1,01} -> JUMP.
- BRWAIT:
  - BranchTaken: {1,0,1,10}, cnt<=BR_FLUSH-1 -> BRFLUSH.
  - Not taken: apply the full IDLE decision to the current inputs, so a jump or hazard following an untaken branch is not lost.
- BRFLUSH: {1,1,1,00}. If cnt==0 -> IDLE, else cnt<=cnt-1.
- MDWAIT: while mdBusy, STALL; when mdBusy==0, NORM -> IDLE.
- Decode flags are ignored in LDSTALL, JUMP, JRWAIT, BRFLUSH and MDWAIT. The pipeline must not present a new instruction there, because IF_Write was 0 or the instruction was squashed.

Width rule: cnt is 2 bits; compare against zero only.

## Timing
- State and cnt register on rising Clk. Outputs are combinational from state and current inputs, with zero latency.
- Reset:
  - While Rst==1, outputs are forced to NORM and hzState reads 0.
  - After the first rising edge with Rst==1, state=IDLE and cnt=0.
  - Reset mid-stall or mid-flush aborts immediately; there is no residual stall.
- Stall cycles seen by PC: load-use = LD_STALL. Jr with a hazard = cycles until no writer stage matches, +1 redirect cycle. Mul/div = cycles with mdBusy high.
- Taken branch: one redirect cycle, then BR_FLUSH bubble cycles.
- Simultaneous Jump & LdHaz: Jump wins, no stall.
- Simultaneous Jr & LdHaz: Jr path wins, and JrHaz covers the load through the wbDst stages.
- currRs==0 or prevRt==0 never stalls.

## Test plan
- LD_STALL=2: memReadEX=1, prevRt=8, currRs=8 -> 2 cycles STALL (LDSTALL entered with cnt=1), then NORM. Repeat with prevRt=0 -> no stall.
- NWB=2: Jr, currRs=31, wbWr=10, wbDst[1]=31 for 2 cycles -> {0,0,1,01} for 2 cycles, then {1,0,1,01}, then JUMP, then NORM.
- BR_FLUSH=2: Branch, then BranchTaken=1 -> {1,0,1,10}, then 2 cycles {1,1,1,00}, then IDLE. Branch with BranchTaken=0 and Jump asserted that cycle -> {1,0,0,01}, JUMP.
- mdUse=1, mdBusy high for 5 cycles -> 5 STALL cycles, NORM on mdBusy fall, hzState 6 then 0.
- Rst=1 asserted during LDSTALL (LD_STALL=3) -> outputs NORM that cycle, IDLE next edge. UseImmed=1 with currRt==prevRt and currRs≠prevRt -> no stall.

Source files
------------

// File: rtl/hazard_ctrl_param_if.sv
// ID-stage hazard controller bus: decode/hazard inputs from the pipeline and
// the PC/IF/ID-EX control outputs back to it.
interface hazard_ctrl_param_if #(
    parameter int RW  = 5,
    parameter int NWB = 2
);
    logic              Jump;
    logic              Jr;
    logic              Branch;
    logic              BranchTaken;
    logic              memReadEX;
    logic              UseShamt;
    logic              UseImmed;
    logic              mdUse;
    logic              mdBusy;
    logic [RW-1:0]     currRs;
    logic [RW-1:0]     currRt;
    logic [RW-1:0]     prevRt;
    logic [NWB*RW-1:0] wbDst;
    logic [NWB-1:0]    wbWr;
    logic              PC_Write;
    logic              IF_Write;
    logic              bubble;
    logic [1:0]        addrSel;
    logic [2:0]        hzState;

    modport master (
        output Jump, Jr, Branch, BranchTaken, memReadEX, UseShamt, UseImmed,
               mdUse, mdBusy, currRs, currRt, prevRt, wbDst, wbWr,
        input  PC_Write, IF_Write, bubble, addrSel, hzState
    );

    modport slave (
        input  Jump, Jr, Branch, BranchTaken, memReadEX, UseShamt, UseImmed,
               mdUse, mdBusy, currRs, currRt, prevRt, wbDst, wbWr,
        output PC_Write, IF_Write, bubble, addrSel, hzState
    );
endinterface

// File: rtl/hazard_ctrl_param.sv
// Parametrised 5-stage MIPS hazard controller: load-use, jump/jr, branch
// redirect/flush and mul/div stalls, with combinational outputs from state.
module hazard_ctrl_param #(
    parameter int RW       = 5,
    parameter int NWB      = 2,
    parameter int LD_STALL = 1,
    parameter int BR_FLUSH = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    hazard_ctrl_param_if.slave hz
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LDSTALL = 3'd1,
        S_JUMP    = 3'd2,
        S_JRWAIT  = 3'd3,
        S_BRWAIT  = 3'd4,
        S_BRFLUSH = 3'd5,
        S_MDWAIT  = 3'd6
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       if_write;
        logic       bubble;
        logic [1:0] addr_sel;
    } ctrl_t;

    localparam ctrl_t NORM    = '{pc_write: 1'b1, if_write: 1'b1, bubble: 1'b0, addr_sel: 2'b00};
    localparam ctrl_t STALL   = '{pc_write: 1'b0, if_write: 1'b0, bubble: 1'b1, addr_sel: 2'b00};
    localparam ctrl_t JMP_GO  = '{pc_write: 1'b1, if_write: 1'b0, bubble: 1'b0, addr_sel: 2'b01};
    localparam ctrl_t JR_HOLD = '{pc_write: 1'b0, if_write: 1'b0, bubble: 1'b1, addr_sel: 2'b01};
    localparam ctrl_t JR_GO   = '{pc_write: 1'b1, if_write: 1'b0, bubble: 1'b1, addr_sel: 2'b01};
    localparam ctrl_t BR_GO   = '{pc_write: 1'b1, if_write: 1'b0, bubble: 1'b1, addr_sel: 2'b10};
    localparam ctrl_t FLUSH   = '{pc_write: 1'b1, if_write: 1'b1, bubble: 1'b1, addr_sel: 2'b00};

    localparam logic [1:0] LD_INIT = 2'(LD_STALL - 1);
    localparam logic [1:0] BR_INIT = 2'(BR_FLUSH - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    ctrl_t      ctrl, ctrl_out;
    logic       ld_haz, jr_haz, jr_match, md_haz;

    ctrl_t      idle_ctrl;
    state_e     idle_state;
    logic [1:0] idle_cnt;

    always_comb begin
        jr_match = 1'b0;
        for (int k = 0; k < NWB; k++) begin
            if (hz.wbWr[k] && (hz.wbDst[k*RW +: RW] == hz.currRs)) jr_match = 1'b1;
        end
    end

    // Register 0 is hard-wired, so a match on it is never a real dependency.
    assign jr_haz = jr_match && (hz.currRs != '0);
    assign ld_haz = hz.memReadEX && (hz.prevRt != '0) &&
                    ((hz.currRs == hz.prevRt) ||
                     ((hz.currRt == hz.prevRt) && !hz.UseImmed && !hz.UseShamt));
    assign md_haz = hz.mdUse && hz.mdBusy;

    // Decision for a freshly decoded instruction; shared by IDLE and by an
    // untaken branch so a jump or hazard right behind the branch is not lost.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        idle_ctrl  = NORM;
        idle_state = S_IDLE;
        idle_cnt   = cnt_q;
        if (hz.Jump) begin
            idle_ctrl  = JMP_GO;
            idle_state = S_JUMP;
        end else if (hz.Jr && jr_haz) begin
            idle_ctrl  = JR_HOLD;
            idle_state = S_JRWAIT;
        end else if (hz.Jr) begin
            idle_ctrl  = JR_GO;
            idle_state = S_JUMP;
        end else if (ld_haz) begin
            idle_ctrl  = STALL;
            idle_cnt   = LD_INIT;
            idle_state = S_LDSTALL;
        end else if (md_haz) begin
            idle_ctrl  = STALL;
            idle_state = S_MDWAIT;
        end else if (hz.Branch) begin
            idle_state = S_BRWAIT;
        end
    end

    always_comb begin
        ctrl    = NORM;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LDSTALL: begin
                if (cnt_q != 2'd0) begin
                    ctrl  = STALL;
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_JUMP: state_d = S_IDLE;
            S_JRWAIT: begin
                if (jr_haz) begin
                    ctrl = JR_HOLD;
                end else begin
                    ctrl    = JR_GO;
                    state_d = S_JUMP;
                end
            end
            S_BRWAIT: begin
                if (hz.BranchTaken) begin
                    ctrl    = BR_GO;
                    cnt_d   = BR_INIT;
                    state_d = S_BRFLUSH;
                end else begin
                    ctrl    = idle_ctrl;
                    state_d = idle_state;
                    cnt_d   = idle_cnt;
                end
            end
            S_BRFLUSH: begin
                ctrl = FLUSH;
                if (cnt_q == 2'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_MDWAIT: begin
                if (hz.mdBusy) ctrl    = STALL;
                else           state_d = S_IDLE;
            end
            default: begin
                // IDLE, and the unused encoding 7 which recovers to IDLE.
                ctrl    = idle_ctrl;
                state_d = idle_state;
                cnt_d   = idle_cnt;
            end
        endcase
    end

    // Reset overrides the outputs combinationally so a stall is dropped the
    // same cycle reset is raised, not one edge later.
    assign ctrl_out    = Rst ? NORM : ctrl;
    assign hz.PC_Write = ctrl_out.pc_write;
    assign hz.IF_Write = ctrl_out.if_write;
    assign hz.bubble   = ctrl_out.bubble;
    assign hz.addrSel  = ctrl_out.addr_sel;
    assign hz.hzState  = Rst ? 3'd0 : 3'(state_q);

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed bench: two controllers (LD_STALL=2/BR_FLUSH=2 and LD_STALL=3/BR_FLUSH=1)
// share the same stimulus; expected {PC_Write,IF_Write,bubble,addrSel,hzState} are hand-derived.
module tb_hazard_ctrl_param;
    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] JMP   = 5'b10001;
    localparam logic [4:0] JRH   = 5'b00101;
    localparam logic [4:0] JRG   = 5'b10101;
    localparam logic [4:0] BRT   = 5'b10110;
    localparam logic [4:0] FLS   = 5'b11100;

    logic       clk = 1'b0;
    logic       rst;
    logic       jump, jr, branch, brtaken, memrd, useshamt, useimmed, mduse, mdbusy;
    logic [4:0] currrs, currrt, prevrt;
    logic [9:0] wbdst;
    logic [1:0] wbwr;
    logic [7:0] exp;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_param_if #(.RW(5), .NWB(2)) bus2 ();
    hazard_ctrl_param_if #(.RW(5), .NWB(2)) bus3 ();

    assign bus2.Jump = jump;            assign bus3.Jump = jump;
    assign bus2.Jr = jr;                assign bus3.Jr = jr;
    assign bus2.Branch = branch;        assign bus3.Branch = branch;
    assign bus2.BranchTaken = brtaken;  assign bus3.BranchTaken = brtaken;
    assign bus2.memReadEX = memrd;      assign bus3.memReadEX = memrd;
    assign bus2.UseShamt = useshamt;    assign bus3.UseShamt = useshamt;
    assign bus2.UseImmed = useimmed;    assign bus3.UseImmed = useimmed;
    assign bus2.mdUse = mduse;          assign bus3.mdUse = mduse;
    assign bus2.mdBusy = mdbusy;        assign bus3.mdBusy = mdbusy;
    assign bus2.currRs = currrs;        assign bus3.currRs = currrs;
    assign bus2.currRt = currrt;        assign bus3.currRt = currrt;
    assign bus2.prevRt = prevrt;        assign bus3.prevRt = prevrt;
    assign bus2.wbDst = wbdst;          assign bus3.wbDst = wbdst;
    assign bus2.wbWr = wbwr;            assign bus3.wbWr = wbwr;

    hazard_ctrl_param #(.RW(5), .NWB(2), .LD_STALL(2), .BR_FLUSH(2)) dut2 (
        .Clk(clk), .Rst(rst), .hz(bus2)
    );
    hazard_ctrl_param #(.RW(5), .NWB(2), .LD_STALL(3), .BR_FLUSH(1)) dut3 (
        .Clk(clk), .Rst(rst), .hz(bus3)
    );

    wire [7:0] o2 = {bus2.PC_Write, bus2.IF_Write, bus2.bubble, bus2.addrSel, bus2.hzState};
    wire [7:0] o3 = {bus3.PC_Write, bus3.IF_Write, bus3.bubble, bus3.addrSel, bus3.hzState};

    task automatic clear_inputs();
        jump = 0; jr = 0; branch = 0; brtaken = 0; memrd = 0; useshamt = 0; useimmed = 0;
        mduse = 0; mdbusy = 0; currrs = '0; currrt = '0; prevrt = '0; wbdst = '0; wbwr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_inputs();
        memrd = 1; prevrt = 5'd8; currrs = 5'd8;
        #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL reset_held d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {NORM, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL reset_held d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        rst = 1'b0; clear_inputs(); #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL reset_after d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {NORM, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL reset_after d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        memrd = 1; prevrt = 5'd8; currrs = 5'd8; #1;
        exp = {STALL, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL ld_c0 d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {STALL, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL ld_c0 d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        exp = {STALL, 3'd1}; n_checks++; if (o2 !== exp) $display("FAIL ld_c1 d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {STALL, 3'd1}; n_checks++; if (o3 !== exp) $display("FAIL ld_c1 d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        exp = {NORM, 3'd1};  n_checks++; if (o2 !== exp) $display("FAIL ld_c2 d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {STALL, 3'd1}; n_checks++; if (o3 !== exp) $display("FAIL ld_c2 d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        clear_inputs(); #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL ld_c3 d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {NORM, 3'd1}; n_checks++; if (o3 !== exp) $display("FAIL ld_c3 d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        exp = {NORM, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL ld_c4 d3: got %b exp %b", o3, exp); else n_pass++;
        // Register 0 as load destination never stalls.
        memrd = 1; prevrt = 5'd0; currrs = 5'd0; currrt = 5'd0; #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL ld_r0 d2: got %b exp %b", o2, exp); else n_pass++;
        tick();
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL ld_r0_next d2: got %b exp %b", o2, exp); else n_pass++;
        prevrt = 5'd9; currrt = 5'd9; currrs = 5'd3; useimmed = 1; #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL ld_immed d2: got %b exp %b", o2, exp); else n_pass++;
        useimmed = 0; useshamt = 1; #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL ld_shamt d2: got %b exp %b", o2, exp); else n_pass++;
        useshamt = 0; #1;
        exp = {STALL, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL ld_rt d2: got %b exp %b", o2, exp); else n_pass++;
    endtask

    task automatic test_jr_hazard();
        do_reset();
        jr = 1; currrs = 5'd31; wbwr = 2'b10; wbdst = {5'd31, 5'd4}; #1;
        exp = {JRH, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL jr_c0: got %b exp %b", o2, exp); else n_pass++;
        tick();
        exp = {JRH, 3'd3}; n_checks++; if (o2 !== exp) $display("FAIL jr_c1: got %b exp %b", o2, exp); else n_pass++;
        tick();
        wbwr = 2'b00; #1;
        exp = {JRG, 3'd3}; n_checks++; if (o2 !== exp) $display("FAIL jr_c2: got %b exp %b", o2, exp); else n_pass++;
        tick();
        jr = 0; #1;
        exp = {NORM, 3'd2}; n_checks++; if (o2 !== exp) $display("FAIL jr_c3: got %b exp %b", o2, exp); else n_pass++;
        tick();
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL jr_c4: got %b exp %b", o2, exp); else n_pass++;
        // Decisions within a single IDLE cycle.
        jr = 1; currrs = 5'd7; wbwr = 2'b01; wbdst = {5'd0, 5'd7}; #1;
        exp = {JRH, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL jr_slot0: got %b exp %b", o2, exp); else n_pass++;
        wbwr = 2'b00; #1;
        exp = {JRG, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL jr_nowrite: got %b exp %b", o2, exp); else n_pass++;
        currrs = 5'd0; wbwr = 2'b11; wbdst = '0; #1;
        exp = {JRG, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL jr_r0: got %b exp %b", o2, exp); else n_pass++;
        jr = 0; jump = 1; wbwr = 2'b00; memrd = 1; prevrt = 5'd8; currrs = 5'd8; #1;
        exp = {JMP, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL jump_over_ld: got %b exp %b", o2, exp); else n_pass++;
        jump = 0; jr = 1; #1;
        exp = {JRG, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL jr_over_ld: got %b exp %b", o2, exp); else n_pass++;
        wbwr = 2'b01; wbdst = {5'd0, 5'd8}; #1;
        exp = {JRH, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL jr_ld_wb: got %b exp %b", o2, exp); else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        branch = 1; #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL br_c0: got %b exp %b", o2, exp); else n_pass++;
        tick();
        branch = 0; brtaken = 1; #1;
        exp = {BRT, 3'd4}; n_checks++; if (o2 !== exp) $display("FAIL br_taken d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {BRT, 3'd4}; n_checks++; if (o3 !== exp) $display("FAIL br_taken d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        brtaken = 0; #1;
        exp = {FLS, 3'd5}; n_checks++; if (o2 !== exp) $display("FAIL br_fl1 d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {FLS, 3'd5}; n_checks++; if (o3 !== exp) $display("FAIL br_fl1 d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        exp = {FLS, 3'd5};  n_checks++; if (o2 !== exp) $display("FAIL br_fl2 d2: got %b exp %b", o2, exp); else n_pass++;
        exp = {NORM, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL br_fl2 d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL br_done d2: got %b exp %b", o2, exp); else n_pass++;
        // Untaken branch followed by a jump in the very next decode.
        branch = 1; tick();
        branch = 0; jump = 1; #1;
        exp = {JMP, 3'd4}; n_checks++; if (o2 !== exp) $display("FAIL br_nt_jump: got %b exp %b", o2, exp); else n_pass++;
        tick();
        jump = 0; #1;
        exp = {NORM, 3'd2}; n_checks++; if (o2 !== exp) $display("FAIL br_nt_jstate: got %b exp %b", o2, exp); else n_pass++;
        tick();
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL br_nt_idle: got %b exp %b", o2, exp); else n_pass++;
    endtask

    task automatic test_muldiv();
        do_reset();
        mduse = 1; mdbusy = 0; #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL md_idle_free: got %b exp %b", o2, exp); else n_pass++;
        mdbusy = 1; #1;
        exp = {STALL, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL md_c0: got %b exp %b", o2, exp); else n_pass++;
        for (int i = 1; i < 5; i++) begin
            tick();
            exp = {STALL, 3'd6}; n_checks++; if (o2 !== exp) $display("FAIL md_c%0d: got %b exp %b", i, o2, exp); else n_pass++;
        end
        tick();
        mdbusy = 0; #1;
        exp = {NORM, 3'd6}; n_checks++; if (o2 !== exp) $display("FAIL md_release: got %b exp %b", o2, exp); else n_pass++;
        tick();
        mduse = 0; #1;
        exp = {NORM, 3'd0}; n_checks++; if (o2 !== exp) $display("FAIL md_idle: got %b exp %b", o2, exp); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        memrd = 1; prevrt = 5'd8; currrs = 5'd8; #1;
        exp = {STALL, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL rst_ld_c0 d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        exp = {STALL, 3'd1}; n_checks++; if (o3 !== exp) $display("FAIL rst_ld_c1 d3: got %b exp %b", o3, exp); else n_pass++;
        rst = 1; #1;
        exp = {NORM, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL rst_mid d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        rst = 0; clear_inputs(); #1;
        exp = {NORM, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL rst_post d3: got %b exp %b", o3, exp); else n_pass++;
        tick();
        exp = {NORM, 3'd0}; n_checks++; if (o3 !== exp) $display("FAIL rst_post2 d3: got %b exp %b", o3, exp); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_jr_hazard();
        test_branch();
        test_muldiv();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
